// File: rtl/uart_boot_loader.sv
// UART program loader: receives a framed image, writes it word-by-word into the instruction ROM,
// and holds the CPU in reset until the image checksum verifies.
//   state  | meaning
//   IDLE   | waiting for the sync byte after reset
//   LEN0   | expecting length low byte
//   LEN1   | expecting length high byte, range check
//   DATA   | collecting data bytes, one ROM write per 4 bytes
//   CSUM   | expecting checksum byte
//   DONE   | image loaded and verified, CPU released
//   ERR    | last frame aborted, CPU held
module uart_boot_loader #(
    parameter int          CLKS_PER_BIT = 868,
    parameter int          ADDR_W       = 10,
    parameter logic [7:0]  SYNC_BYTE    = 8'hA5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_rx,
    output logic              o_mem_we,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic [31:0]       o_mem_wdata,
    output logic              o_cpu_hold,
    output logic              o_boot_done,
    output logic              o_boot_err
);

    localparam int              CNT_W     = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [31:0]     MAX_WORDS = 32'(1) << ADDR_W;

    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
    typedef enum logic [2:0] {S_IDLE, S_LEN0, S_LEN1, S_DATA, S_CSUM, S_DONE, S_ERR} state_t;

    rx_state_t        rx_state, rx_next;
    logic             rx_meta, rx_sync;
    logic [CNT_W-1:0] rx_cnt;
    logic [2:0]       rx_bit;
    logic [7:0]       rx_shift;
    logic             rx_valid, rx_ferr;
    logic             rx_tc;

    state_t           state, state_next;
    logic [7:0]       len_lo, csum;
    logic [15:0]      len_m1, len_rx;
    logic [ADDR_W-1:0] word_idx;
    logic [1:0]       byte_idx;
    logic [23:0]      word_buf;
    logic             len_bad, last_word, is_sync;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
        end else begin
            rx_meta <= i_rx;
            rx_sync <= rx_meta;
        end
    end

    assign rx_tc = (rx_cnt == '0);

    always_comb begin
        rx_next = rx_state;
        case (rx_state)
            RX_IDLE:  if (!rx_sync) rx_next = RX_START;
            RX_START: if (rx_tc) rx_next = rx_sync ? RX_IDLE : RX_DATA;
            RX_DATA:  if (rx_tc && rx_bit == 3'd7) rx_next = RX_STOP;
            RX_STOP:  if (rx_tc) rx_next = RX_IDLE;
            default:  rx_next = RX_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_state <= RX_IDLE;
            rx_cnt   <= '0;
            rx_bit   <= '0;
            rx_shift <= '0;
            rx_valid <= 1'b0;
            rx_ferr  <= 1'b0;
        end else begin
            rx_state <= rx_next;
            rx_valid <= 1'b0;
            rx_ferr  <= 1'b0;
            case (rx_state)
                RX_IDLE: rx_cnt <= CNT_HALF;
                RX_START: begin
                    rx_cnt <= rx_tc ? CNT_FULL : rx_cnt - 1'b1;
                    rx_bit <= '0;
                end
                RX_DATA: begin
                    if (rx_tc) begin
                        rx_shift <= {rx_sync, rx_shift[7:1]};
                        rx_bit   <= rx_bit + 3'd1;
                        rx_cnt   <= CNT_FULL;
                    end else begin
                        rx_cnt <= rx_cnt - 1'b1;
                    end
                end
                RX_STOP: begin
                    if (rx_tc) begin
                        rx_valid <= rx_sync;
                        rx_ferr  <= ~rx_sync;
                    end else begin
                        rx_cnt <= rx_cnt - 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign len_rx    = {rx_shift, len_lo};
    assign len_bad   = (len_rx == 16'd0) || (32'(len_rx) > MAX_WORDS);
    assign last_word = (32'(word_idx) == 32'(len_m1));
    assign is_sync   = (rx_shift == SYNC_BYTE);

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE, S_DONE, S_ERR:
                if (rx_valid && is_sync) state_next = S_LEN0;
            S_LEN0:
                if (rx_ferr) state_next = S_ERR;
                else if (rx_valid) state_next = S_LEN1;
            S_LEN1:
                if (rx_ferr) state_next = S_ERR;
                else if (rx_valid) state_next = len_bad ? S_ERR : S_DATA;
            S_DATA:
                if (rx_ferr) state_next = S_ERR;
                else if (rx_valid && byte_idx == 2'd3 && last_word) state_next = S_CSUM;
            S_CSUM:
                if (rx_ferr) state_next = S_ERR;
                else if (rx_valid) state_next = (rx_shift == csum) ? S_DONE : S_ERR;
            default: state_next = S_IDLE;
        endcase
    end

    // Status flags are registered decodes of the next state, so they change with the state itself.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= S_IDLE;
            o_mem_we    <= 1'b0;
            o_mem_addr  <= '0;
            o_mem_wdata <= '0;
            o_cpu_hold  <= 1'b1;
            o_boot_done <= 1'b0;
            o_boot_err  <= 1'b0;
            len_lo      <= '0;
            len_m1      <= '0;
            csum        <= '0;
            word_idx    <= '0;
            byte_idx    <= '0;
            word_buf    <= '0;
        end else begin
            state       <= state_next;
            o_mem_we    <= 1'b0;
            o_cpu_hold  <= (state_next != S_DONE);
            o_boot_done <= (state_next == S_DONE);
            o_boot_err  <= (state_next == S_ERR);
            if (rx_valid) begin
                case (state)
                    S_LEN0: len_lo <= rx_shift;
                    S_LEN1: begin
                        len_m1   <= len_rx - 16'd1;
                        word_idx <= '0;
                        byte_idx <= '0;
                        csum     <= '0;
                    end
                    S_DATA: begin
                        csum     <= csum ^ rx_shift;
                        byte_idx <= byte_idx + 2'd1;
                        case (byte_idx)
                            2'd0: word_buf[7:0]   <= rx_shift;
                            2'd1: word_buf[15:8]  <= rx_shift;
                            2'd2: word_buf[23:16] <= rx_shift;
                            default: begin
                                o_mem_we    <= 1'b1;
                                o_mem_addr  <= word_idx;
                                o_mem_wdata <= {rx_shift, word_buf};
                                word_idx    <= word_idx + 1'b1;
                            end
                        endcase
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_uart_boot_loader.sv
// Directed bench for uart_boot_loader: drives UART frames bit by bit and checks ROM writes
// and boot status against hand-computed values.
module tb_uart_boot_loader;

    localparam int CPB    = 16;
    localparam int ADDR_W = 10;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              i_rx = 1'b1;
    logic              o_mem_we;
    logic [ADDR_W-1:0] o_mem_addr;
    logic [31:0]       o_mem_wdata;
    logic              o_cpu_hold;
    logic              o_boot_done;
    logic              o_boot_err;

    int          n_assert = 0;
    int          n_fail   = 0;
    int          wr_cnt   = 0;
    logic [31:0] wr_addr [16];
    logic [31:0] wr_data [16];

    uart_boot_loader #(
        .CLKS_PER_BIT (CPB),
        .ADDR_W       (ADDR_W),
        .SYNC_BYTE    (8'hA5)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .i_rx        (i_rx),
        .o_mem_we    (o_mem_we),
        .o_mem_addr  (o_mem_addr),
        .o_mem_wdata (o_mem_wdata),
        .o_cpu_hold  (o_cpu_hold),
        .o_boot_done (o_boot_done),
        .o_boot_err  (o_boot_err)
    );

    always #5 clk = ~clk;

    // Every cycle with the strobe high is one recorded write; a stretched strobe shows up as extras.
    always @(negedge clk) begin
        if (o_mem_we === 1'b1) begin
            if (wr_cnt < 16) begin
                wr_addr[wr_cnt] = 32'(o_mem_addr);
                wr_data[wr_cnt] = o_mem_wdata;
            end
            wr_cnt = wr_cnt + 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic bit_time();
        repeat (CPB) @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop);
        i_rx = 1'b0;
        bit_time();
        for (int i = 0; i < 8; i++) begin
            i_rx = b[i];
            bit_time();
        end
        i_rx = stop;
        bit_time();
        i_rx = 1'b1;
        bit_time();
        bit_time();
    endtask

    task automatic glitch();
        i_rx = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        i_rx = 1'b1;
        bit_time();
        bit_time();
    endtask

    // Body of the two-word frame (after the sync byte); optional glitch mid-word.
    task automatic send_body(input logic [7:0] cs, input bit with_glitch);
        send_byte(8'h02, 1'b1);
        send_byte(8'h00, 1'b1);
        send_byte(8'h13, 1'b1);
        send_byte(8'h00, 1'b1);
        if (with_glitch) glitch();
        send_byte(8'h00, 1'b1);
        send_byte(8'h00, 1'b1);
        send_byte(8'h93, 1'b1);
        send_byte(8'h05, 1'b1);
        send_byte(8'h10, 1'b1);
        send_byte(8'h00, 1'b1);
        send_byte(cs, 1'b1);
    endtask

    task automatic chk_words(input int base, input string tag);
        chk({tag, "_cnt"},   32'(wr_cnt), 32'(base + 2));
        chk({tag, "_addr0"}, wr_addr[base],     32'd0);
        chk({tag, "_data0"}, wr_data[base],     32'h0000_0013);
        chk({tag, "_addr1"}, wr_addr[base + 1], 32'd1);
        chk({tag, "_data1"}, wr_data[base + 1], 32'h0010_0593);
    endtask

    task automatic chk_status(input string tag, input logic hold, input logic done, input logic err);
        chk({tag, "_hold"}, 32'(o_cpu_hold),  32'(hold));
        chk({tag, "_done"}, 32'(o_boot_done), 32'(done));
        chk({tag, "_err"},  32'(o_boot_err),  32'(err));
    endtask

    initial begin
        for (int i = 0; i < 16; i++) begin
            wr_addr[i] = '0;
            wr_data[i] = '0;
        end

        // Reset values, then a long idle line
        repeat (3) @(posedge clk);
        #1;
        chk_status("rst", 1'b1, 1'b0, 1'b0);
        chk("rst_we",    32'(o_mem_we),   32'd0);
        chk("rst_addr",  32'(o_mem_addr), 32'd0);
        chk("rst_wdata", o_mem_wdata,     32'd0);
        rst = 1'b1;
        repeat (10000) @(posedge clk);
        #1;
        chk_status("idle", 1'b1, 1'b0, 1'b0);
        chk("idle_wr_cnt", 32'(wr_cnt), 32'd0);

        // Good frame, checksum 0x95
        send_byte(8'hA5, 1'b1);
        send_body(8'h95, 1'b0);
        chk_words(0, "good");
        chk_status("good", 1'b0, 1'b1, 1'b0);

        // Same frame, wrong checksum: words still written
        send_byte(8'hA5, 1'b1);
        chk_status("reload_sync", 1'b1, 1'b0, 1'b0);
        send_body(8'h00, 1'b0);
        chk_words(2, "badcs");
        chk_status("badcs", 1'b1, 1'b0, 1'b1);

        // Zero length and oversize length
        send_byte(8'hA5, 1'b1);
        chk_status("len0_sync", 1'b1, 1'b0, 1'b0);
        send_byte(8'h00, 1'b1);
        send_byte(8'h00, 1'b1);
        chk_status("len0", 1'b1, 1'b0, 1'b1);
        send_byte(8'hA5, 1'b1);
        send_byte(8'h01, 1'b1);
        send_byte(8'h04, 1'b1);
        chk_status("len401", 1'b1, 1'b0, 1'b1);
        chk("len_wr_cnt", 32'(wr_cnt), 32'd4);

        // Framing error in the first data byte, rest of the frame ignored
        send_byte(8'hA5, 1'b1);
        send_byte(8'h02, 1'b1);
        send_byte(8'h00, 1'b1);
        send_byte(8'h13, 1'b0);
        chk_status("ferr", 1'b1, 1'b0, 1'b1);
        send_byte(8'h00, 1'b1);
        send_byte(8'h00, 1'b1);
        send_byte(8'h00, 1'b1);
        send_byte(8'h93, 1'b1);
        send_byte(8'h05, 1'b1);
        send_byte(8'h10, 1'b1);
        send_byte(8'h00, 1'b1);
        send_byte(8'h95, 1'b1);
        chk_status("ferr_tail", 1'b1, 1'b0, 1'b1);
        chk("ferr_wr_cnt", 32'(wr_cnt), 32'd4);
        send_byte(8'hA5, 1'b1);
        chk_status("recover_sync", 1'b1, 1'b0, 1'b0);
        send_body(8'h95, 1'b0);
        chk_words(4, "recover");
        chk_status("recover", 1'b0, 1'b1, 1'b0);

        // Reset in the middle of a data byte
        send_byte(8'hA5, 1'b1);
        send_byte(8'h02, 1'b1);
        send_byte(8'h00, 1'b1);
        send_byte(8'h13, 1'b1);
        send_byte(8'h00, 1'b1);
        i_rx = 1'b0;
        repeat (CPB / 2 + 3) @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        chk_status("midrst", 1'b1, 1'b0, 1'b0);
        chk("midrst_we",    32'(o_mem_we),   32'd0);
        chk("midrst_addr",  32'(o_mem_addr), 32'd0);
        chk("midrst_wdata", o_mem_wdata,     32'd0);
        repeat (3) @(posedge clk);
        #1;
        i_rx = 1'b1;
        rst  = 1'b1;
        bit_time();
        bit_time();

        // Short low glitches in IDLE and between data bytes are not bytes
        glitch();
        chk_status("glitch_idle", 1'b1, 1'b0, 1'b0);
        chk("glitch_wr_cnt", 32'(wr_cnt), 32'd6);
        send_byte(8'hA5, 1'b1);
        send_body(8'h95, 1'b1);
        chk_words(6, "fresh");
        chk_status("fresh", 1'b0, 1'b1, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
